// File: rtl/excp_commit.sv
// Commit-point controller: exception/interrupt priority, CSR read-modify-write,
// CSR exception bus and flush sequencing. Optional counters under EXCP_STATS_EN.
`ifndef CSR_BUS_WD
`define CSR_BUS_WD 82
`endif

module excp_commit #(
    parameter int unsigned EENTRY_UNUSED = 0,
    parameter int unsigned FLUSH_MIN     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmt_valid,
    output logic                   cmt_ready,
    input  logic [31:0]            cmt_pc,
    input  logic [4:0]             cmt_excp,
    input  logic [31:0]            cmt_badv,
    input  logic                   cmt_is_ertn,
    input  logic [1:0]             cmt_csr_op,
    input  logic [13:0]            cmt_csr_addr,
    input  logic [31:0]            cmt_rd_val,
    input  logic [31:0]            cmt_rj_val,
    output logic [13:0]            csr_raddr,
    input  logic [31:0]            csr_rdata,
    input  logic                   have_intrpt,
    output logic                   csr_wen,
    output logic [13:0]            csr_waddr,
    output logic [31:0]            csr_wdata,
    output logic [`CSR_BUS_WD-1:0] csr_bus,
    output logic                   flush_req,
    input  logic                   flush_ack
`ifdef EXCP_STATS_EN
    ,
    output logic [31:0]            stat_excp_cnt,
    output logic [31:0]            stat_ertn_cnt
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] FLUSH_MIN_C = CNT_W'(FLUSH_MIN);

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [1:0] OP_CSRWR   = 2'b10;
    localparam logic [1:0] OP_CSRXCHG = 2'b11;

    typedef struct packed {
        logic        is_etrn;
        logic        in_excp;
        logic [5:0]  ecode;
        logic [8:0]  subecode;
        logic [31:0] era;
        logic        use_badv;
        logic [31:0] badv;
    } csr_bus_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CSRW  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // The entry PC is owned by the CSR file; a non-zero value is a build error.
    if (EENTRY_UNUSED != 0) begin : g_eentry_check
        $error("excp_commit: EENTRY_UNUSED must be 0");
    end

    state_t           state;
    csr_bus_t         bus_q;
    logic [CNT_W-1:0] flush_cnt;

    logic             accept_c;
    logic             excp_take_c;
    logic [5:0]       excp_code_c;
    logic             excp_use_badv_c;
    logic [31:0]      excp_badv_c;
    logic             csr_write_c;
    logic [31:0]      csr_wdata_c;

    assign csr_raddr = cmt_csr_addr;
    assign csr_bus   = `CSR_BUS_WD'(bus_q);
    assign accept_c  = cmt_valid & cmt_ready;

    // Priority resolution: interrupt first, then ADEF, INE, SYS, BRK, ALE.
    always_comb begin
        excp_take_c     = 1'b1;
        excp_code_c     = 6'h00;
        excp_use_badv_c = 1'b0;
        excp_badv_c     = 32'h0;
        if (have_intrpt) begin
            excp_code_c = ECODE_INT;
        end else if (cmt_excp[4]) begin
            excp_code_c     = ECODE_ADEF;
            excp_use_badv_c = 1'b1;
            excp_badv_c     = cmt_pc;
        end else if (cmt_excp[3]) begin
            excp_code_c = ECODE_INE;
        end else if (cmt_excp[2]) begin
            excp_code_c = ECODE_SYS;
        end else if (cmt_excp[1]) begin
            excp_code_c = ECODE_BRK;
        end else if (cmt_excp[0]) begin
            excp_code_c     = ECODE_ALE;
            excp_use_badv_c = 1'b1;
            excp_badv_c     = cmt_badv;
        end else begin
            excp_take_c = 1'b0;
        end
    end

    // csrxchg merges rd into the current CSR value under the rj mask.
    always_comb begin
        csr_write_c = (cmt_csr_op == OP_CSRWR) || (cmt_csr_op == OP_CSRXCHG);
        csr_wdata_c = cmt_rd_val;
        if (cmt_csr_op == OP_CSRXCHG) begin
            csr_wdata_c = (cmt_rd_val & cmt_rj_val) | (csr_rdata & ~cmt_rj_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmt_ready <= 1'b0;
            csr_wen   <= 1'b0;
            csr_waddr <= 14'h0;
            csr_wdata <= 32'h0;
            bus_q     <= '0;
            flush_req <= 1'b0;
            flush_cnt <= '0;
        end else begin
            csr_wen <= 1'b0;
            bus_q   <= '0;
            case (state)
                IDLE: begin
                    cmt_ready <= 1'b1;
                    if (accept_c) begin
                        if (excp_take_c) begin
                            bus_q.in_excp  <= 1'b1;
                            bus_q.ecode    <= excp_code_c;
                            bus_q.era      <= cmt_pc;
                            bus_q.use_badv <= excp_use_badv_c;
                            bus_q.badv     <= excp_badv_c;
                            state          <= FLUSH;
                            cmt_ready      <= 1'b0;
                            flush_req      <= 1'b1;
                            flush_cnt      <= CNT_W'(1);
                        end else if (cmt_is_ertn) begin
                            bus_q.is_etrn <= 1'b1;
                            state         <= FLUSH;
                            cmt_ready     <= 1'b0;
                            flush_req     <= 1'b1;
                            flush_cnt     <= CNT_W'(1);
                        end else if (csr_write_c) begin
                            csr_wen   <= 1'b1;
                            csr_waddr <= cmt_csr_addr;
                            csr_wdata <= csr_wdata_c;
                            state     <= CSRW;
                            cmt_ready <= 1'b0;
                        end
                    end
                end
                CSRW: begin
                    state     <= IDLE;
                    cmt_ready <= 1'b1;
                end
                FLUSH: begin
                    // Hold for FLUSH_MIN cycles, then until the frontend acknowledges.
                    if ((flush_cnt >= FLUSH_MIN_C) && flush_ack) begin
                        state     <= IDLE;
                        flush_req <= 1'b0;
                        cmt_ready <= 1'b1;
                    end else if (flush_cnt < FLUSH_MIN_C) begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                    cmt_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXCP_STATS_EN
    // Counters advance on the same edge that raises the corresponding pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_excp_cnt <= 32'h0;
            stat_ertn_cnt <= 32'h0;
        end else if ((state == IDLE) && accept_c) begin
            if (excp_take_c) begin
                stat_excp_cnt <= stat_excp_cnt + 32'h1;
            end else if (cmt_is_ertn) begin
                stat_ertn_cnt <= stat_ertn_cnt + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_excp_commit.sv
// Directed self-checking bench for excp_commit (built with FLUSH_MIN=3).
`ifndef CSR_BUS_WD
`define CSR_BUS_WD 82
`endif

module tb_excp_commit;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmt_valid;
    logic                   cmt_ready;
    logic [31:0]            cmt_pc;
    logic [4:0]             cmt_excp;
    logic [31:0]            cmt_badv;
    logic                   cmt_is_ertn;
    logic [1:0]             cmt_csr_op;
    logic [13:0]            cmt_csr_addr;
    logic [31:0]            cmt_rd_val;
    logic [31:0]            cmt_rj_val;
    logic [13:0]            csr_raddr;
    logic [31:0]            csr_rdata;
    logic                   have_intrpt;
    logic                   csr_wen;
    logic [13:0]            csr_waddr;
    logic [31:0]            csr_wdata;
    logic [`CSR_BUS_WD-1:0] csr_bus;
    logic                   flush_req;
    logic                   flush_ack;
`ifdef EXCP_STATS_EN
    logic [31:0]            stat_excp_cnt;
    logic [31:0]            stat_ertn_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    excp_commit #(.EENTRY_UNUSED(0), .FLUSH_MIN(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmt_valid    (cmt_valid),
        .cmt_ready    (cmt_ready),
        .cmt_pc       (cmt_pc),
        .cmt_excp     (cmt_excp),
        .cmt_badv     (cmt_badv),
        .cmt_is_ertn  (cmt_is_ertn),
        .cmt_csr_op   (cmt_csr_op),
        .cmt_csr_addr (cmt_csr_addr),
        .cmt_rd_val   (cmt_rd_val),
        .cmt_rj_val   (cmt_rj_val),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .have_intrpt  (have_intrpt),
        .csr_wen      (csr_wen),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .csr_bus      (csr_bus),
        .flush_req    (flush_req),
        .flush_ack    (flush_ack)
`ifdef EXCP_STATS_EN
        ,
        .stat_excp_cnt(stat_excp_cnt),
        .stat_ertn_cnt(stat_ertn_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bus field views: {is_etrn, in_excp, ecode, subecode, era, use_badv, badv}
    wire        b_is_etrn  = csr_bus[81];
    wire        b_in_excp  = csr_bus[80];
    wire [5:0]  b_ecode    = csr_bus[79:74];
    wire [8:0]  b_sub      = csr_bus[73:65];
    wire [31:0] b_era      = csr_bus[64:33];
    wire        b_use_badv = csr_bus[32];
    wire [31:0] b_badv     = csr_bus[31:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmt_valid    = 1'b0;
        cmt_excp     = 5'b0;
        cmt_is_ertn  = 1'b0;
        cmt_csr_op   = 2'b00;
        have_intrpt  = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmt_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(cmt_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush_ack = 1'b0; csr_rdata = 32'h0;
        cmt_pc = 32'h0; cmt_badv = 32'h0; cmt_csr_addr = 14'h0;
        cmt_rd_val = 32'h0; cmt_rj_val = 32'h0;
        idle_inputs();
        step();
        check("rst_ready", 32'(cmt_ready), 32'd0);
        check("rst_flush", 32'(flush_req), 32'd0);
        check("rst_wen",   32'(csr_wen), 32'd0);
        check("rst_bus0",  csr_bus[31:0], 32'h0);
        check("rst_bus1",  csr_bus[63:32], 32'h0);
        check("rst_bus2",  32'(csr_bus[81:64]), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(cmt_ready), 32'd1);

        // csrxchg read-modify-write
        cmt_valid = 1'b1; cmt_csr_op = 2'b11; cmt_csr_addr = 14'h30; cmt_pc = 32'h1C000000;
        cmt_rd_val = 32'hAAAA5555; cmt_rj_val = 32'h0000FFFF; csr_rdata = 32'h12345678;
        #1;
        check("raddr", 32'(csr_raddr), 32'h30);
        step();
        idle_inputs();
        check("xchg_wen",   32'(csr_wen), 32'd1);
        check("xchg_waddr", 32'(csr_waddr), 32'h30);
        check("xchg_wdata", csr_wdata, 32'h12345555);
        check("xchg_ready", 32'(cmt_ready), 32'd0);
        check("xchg_excp",  32'(b_in_excp), 32'd0);
        step();
        check("xchg_wen_pulse", 32'(csr_wen), 32'd0);
        check("xchg_ready2",    32'(cmt_ready), 32'd1);

        // csrwr then csrrd
        cmt_valid = 1'b1; cmt_csr_op = 2'b10; cmt_csr_addr = 14'h5; cmt_rd_val = 32'hDEADBEEF;
        step();
        idle_inputs();
        check("wr_wen",   32'(csr_wen), 32'd1);
        check("wr_waddr", 32'(csr_waddr), 32'h5);
        check("wr_wdata", csr_wdata, 32'hDEADBEEF);
        step();
        cmt_valid = 1'b1; cmt_csr_op = 2'b01;
        step();
        idle_inputs();
        check("rd_wen",   32'(csr_wen), 32'd0);
        check("rd_ready", 32'(cmt_ready), 32'd1);

        // SYS+BRK: SYS wins, flush held until ack
        cmt_valid = 1'b1; cmt_excp = 5'b00110; cmt_pc = 32'h1C000100;
        step();
        idle_inputs();
        check("sys_in_excp", 32'(b_in_excp), 32'd1);
        check("sys_ecode",   32'(b_ecode), 32'h0B);
        check("sys_sub",     32'(b_sub), 32'h0);
        check("sys_era",     b_era, 32'h1C000100);
        check("sys_use_badv", 32'(b_use_badv), 32'd0);
        check("sys_wen",     32'(csr_wen), 32'd0);
        check("sys_flush",   32'(flush_req), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("sys_flush_hold", 32'(flush_req), 32'd1);
        check("sys_excp_pulse", 32'(b_in_excp), 32'd0);
        check("sys_ready_hold", 32'(cmt_ready), 32'd0);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        check("sys_flush_done", 32'(flush_req), 32'd0);
        check("sys_ready",      32'(cmt_ready), 32'd1);

        // ALE with ack held: flush_req lasts exactly FLUSH_MIN=3 cycles
        flush_ack = 1'b1;
        cmt_valid = 1'b1; cmt_excp = 5'b00001; cmt_badv = 32'h3; cmt_pc = 32'h1C000180;
        step();
        idle_inputs();
        check("ale_ecode",    32'(b_ecode), 32'h09);
        check("ale_use_badv", 32'(b_use_badv), 32'd1);
        check("ale_badv",     b_badv, 32'h3);
        check("ale_flush1",   32'(flush_req), 32'd1);
        step();
        check("ale_flush2",   32'(flush_req), 32'd1);
        step();
        check("ale_flush3",   32'(flush_req), 32'd1);
        step();
        check("ale_flush4",   32'(flush_req), 32'd0);
        check("ale_ready",    32'(cmt_ready), 32'd1);
        step();
        check("ale_ack_ignored", 32'(flush_req), 32'd0);

        // Interrupt while nothing retires is not taken
        have_intrpt = 1'b1;
        step();
        check("int_novalid", 32'(b_in_excp), 32'd0);
        check("int_novalid_flush", 32'(flush_req), 32'd0);

        // Interrupt on csrwr suppresses the write
        cmt_valid = 1'b1; cmt_csr_op = 2'b10; cmt_pc = 32'h1C000200; cmt_rd_val = 32'h55;
        step();
        idle_inputs();
        check("int_in_excp", 32'(b_in_excp), 32'd1);
        check("int_ecode",   32'(b_ecode), 32'h00);
        check("int_era",     b_era, 32'h1C000200);
        check("int_wen",     32'(csr_wen), 32'd0);
        wait_ready("int_idle");

        // ertn with ADEF: exception wins
        cmt_valid = 1'b1; cmt_is_ertn = 1'b1; cmt_excp = 5'b10000; cmt_pc = 32'h8;
        step();
        idle_inputs();
        check("adef_in_excp", 32'(b_in_excp), 32'd1);
        check("adef_etrn",    32'(b_is_etrn), 32'd0);
        check("adef_ecode",   32'(b_ecode), 32'h08);
        check("adef_badv",    b_badv, 32'h8);
        check("adef_use_badv", 32'(b_use_badv), 32'd1);
        wait_ready("adef_idle");

        // Plain ertn
        cmt_valid = 1'b1; cmt_is_ertn = 1'b1; cmt_pc = 32'h1C000300;
        step();
        idle_inputs();
        check("ertn_etrn",  32'(b_is_etrn), 32'd1);
        check("ertn_excp",  32'(b_in_excp), 32'd0);
        check("ertn_wen",   32'(csr_wen), 32'd0);
        check("ertn_era",   b_era, 32'h0);
        check("ertn_flush", 32'(flush_req), 32'd1);
        step();
        check("ertn_pulse", 32'(b_is_etrn), 32'd0);
        wait_ready("ertn_idle");

        // Reset during FLUSH with no ack
        flush_ack = 1'b0;
        cmt_valid = 1'b1; cmt_excp = 5'b00010; cmt_pc = 32'h1C000400;
        step();
        idle_inputs();
        check("brk_ecode", 32'(b_ecode), 32'h0C);
        step();
        check("brk_flush", 32'(flush_req), 32'd1);
        rst = 1'b1;
        step();
        check("rstf_flush", 32'(flush_req), 32'd0);
        check("rstf_ready", 32'(cmt_ready), 32'd0);
`ifdef EXCP_STATS_EN
        check("rstf_excp_cnt", stat_excp_cnt, 32'h0);
        check("rstf_ertn_cnt", stat_ertn_cnt, 32'h0);
`endif
        rst = 1'b0;
        step();
        check("rstf_ready2", 32'(cmt_ready), 32'd1);
        check("rstf_flush2", 32'(flush_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
